// File: rtl/button_event_pkg.sv
// Package btn_pkg: shared types and helpers for the button event classifier.
//   btn_state_t : FSM state encoding for button_event.
//   cnt_width   : width of the single counter shared by the long-press,
//                 double-click gap and auto-repeat timers.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    WAIT_SECOND    = 3'd2,
    SECOND_PRESSED = 3'd3,
    LONG_HELD      = 3'd4
  } btn_state_t;

  // The counter never needs to hold more than (limit - 1) for the largest
  // of the three limits, so $clog2(limit) bits are enough. Floor of 1 bit
  // keeps the vector legal for degenerate parameter values.
  function automatic int cnt_width(input int long_cycles,
                                   input int gap_cycles,
                                   input int repeat_cycles);
    int m;
    m = long_cycles;
    if (gap_cycles > m) m = gap_cycles;
    if (repeat_cycles > m) m = repeat_cycles;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/button_event_if.sv
// Interface button_event_if: debounced button level in, event pulses out.
//   btn_db        : debounced button level (source -> classifier)
//   held          : registered copy of btn_db
//   press_pulse   : one cycle per rise
//   release_pulse : one cycle per fall
//   click         : short press with no second press inside the gap
//   double_click  : rise of a second short press inside the gap
//   long_press    : hold reached the long-press length
//   repeat_pulse  : periodic pulse while a long press is held
// Modports: master = button source / event consumer, slave = classifier.
interface button_event_if;
  logic btn_db;
  logic held;
  logic press_pulse;
  logic release_pulse;
  logic click;
  logic double_click;
  logic long_press;
  logic repeat_pulse;

  modport master (
    output btn_db,
    input  held, press_pulse, release_pulse, click,
    input  double_click, long_press, repeat_pulse
  );

  modport slave (
    input  btn_db,
    output held, press_pulse, release_pulse, click,
    output double_click, long_press, repeat_pulse
  );
endinterface

// File: rtl/button_event_edge_detect.sv
// edge_detect: one-register rise/fall detector.
//   clk  : clock (rising edge)
//   rst  : synchronous active-low reset, clears q
//   d    : level input, synchronous to clk
//   q    : d from the previous edge
//   rise : d & ~q (combinational)
//   fall : ~d & q (combinational)
// q resets to 0, so a level already high when reset releases shows up as
// a fresh rise on the first edge afterwards.
module edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic q_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      q_reg <= 1'b0;
    end else begin
      q_reg <= d;
    end
  end

  assign q    = q_reg;
  assign rise = d & ~q_reg;
  assign fall = ~d & q_reg;

endmodule

// File: rtl/button_event.sv
// button_event: turns the debounced button level into single-cycle event
// pulses (press, release, click, double-click, long-press, auto-repeat).
//   clk : clock (rising edge)
//   rst : synchronous active-low reset
//   bus : button_event_if.slave (btn_db in, held and event pulses out)
// Parameters (each must be >= 2):
//   LONG_CYCLES       : sampled-high edges that make a long press
//   DOUBLE_GAP_CYCLES : edges after a release in which a rise is a double-click
//   REPEAT_CYCLES     : edges between repeat pulses during a long hold
// Every output is registered; a decision taken at an edge is visible for
// exactly the following cycle.
module button_event
  import btn_pkg::*;
#(
  parameter int LONG_CYCLES       = 8,
  parameter int DOUBLE_GAP_CYCLES = 4,
  parameter int REPEAT_CYCLES     = 3
) (
  input  logic clk,
  input  logic rst,
  button_event_if.slave bus
);

  localparam int CW = cnt_width(LONG_CYCLES, DOUBLE_GAP_CYCLES, REPEAT_CYCLES);
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(DOUBLE_GAP_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE     = CW'(1);

  logic btn_q;
  logic rise;
  logic fall;

  edge_detect u_edge (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.btn_db),
    .q    (btn_q),
    .rise (rise),
    .fall (fall)
  );

  btn_state_t    state_reg;
  logic [CW-1:0] cnt_reg;
  logic          press_reg;
  logic          release_reg;
  logic          click_reg;
  logic          double_reg;
  logic          long_reg;
  logic          repeat_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      press_reg   <= 1'b0;
      release_reg <= 1'b0;
      click_reg   <= 1'b0;
      double_reg  <= 1'b0;
      long_reg    <= 1'b0;
      repeat_reg  <= 1'b0;
    end else begin
      // Edge pulses are independent of the classifier state.
      press_reg   <= rise;
      release_reg <= fall;
      click_reg   <= 1'b0;
      double_reg  <= 1'b0;
      long_reg    <= 1'b0;
      repeat_reg  <= 1'b0;

      case (state_reg)
        IDLE: begin
          // The rise edge itself counts as the first high sample.
          if (rise) begin
            state_reg <= PRESSED;
            cnt_reg   <= CNT_ONE;
          end
        end

        PRESSED: begin
          // Release is checked before the long-press limit, so letting go
          // on the very edge the limit would be reached is still short.
          if (!bus.btn_db) begin
            state_reg <= WAIT_SECOND;
            cnt_reg   <= '0;
          end else if (cnt_reg == LONG_LAST) begin
            long_reg  <= 1'b1;
            state_reg <= LONG_HELD;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        WAIT_SECOND: begin
          // A second rise wins over gap expiry on the same edge.
          if (bus.btn_db) begin
            double_reg <= 1'b1;
            state_reg  <= SECOND_PRESSED;
            cnt_reg    <= '0;
          end else if (cnt_reg == GAP_LAST) begin
            click_reg <= 1'b1;
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        SECOND_PRESSED: begin
          if (!bus.btn_db) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end
        end

        LONG_HELD: begin
          if (!bus.btn_db) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
          end else if (cnt_reg == REPEAT_LAST) begin
            repeat_reg <= 1'b1;
            cnt_reg    <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_ONE;
          end
        end

        default: begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end
      endcase
    end
  end

  assign bus.held          = btn_q;
  assign bus.press_pulse   = press_reg;
  assign bus.release_pulse = release_reg;
  assign bus.click         = click_reg;
  assign bus.double_click  = double_reg;
  assign bus.long_press    = long_reg;
  assign bus.repeat_pulse  = repeat_reg;

endmodule

// File: tb/tb_button_event.sv
// Directed testbench for button_event (LONG=8, GAP=4, REPEAT=3).
// Each vector gives, per edge index, the btn_db level, whether rst is low,
// and the expected outputs in the cycle after that edge, as bit masks.
module tb_button_event;
  import btn_pkg::*;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  button_event_if bus ();

  button_event #(
    .LONG_CYCLES       (8),
    .DOUBLE_GAP_CYCLES (4),
    .REPEAT_CYCLES     (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle to the following negedge for sampling.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.btn_db = 1'b0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  function automatic logic [6:0] obs_word();
    return {bus.held, bus.press_pulse, bus.release_pulse, bus.click,
            bus.double_click, bus.long_press, bus.repeat_pulse};
  endfunction

  task automatic run_vec(input string name, input int n,
                         input bit [31:0] btn, input bit [31:0] rst_low,
                         input bit [31:0] e_held, input bit [31:0] e_press,
                         input bit [31:0] e_rel, input bit [31:0] e_click,
                         input bit [31:0] e_dbl, input bit [31:0] e_long,
                         input bit [31:0] e_rep);
    logic [6:0] exp;
    int         line_fails;
    line_fails = fails;
    for (int i = 0; i < n; i++) begin
      bus.btn_db = btn[i];
      rst = ~rst_low[i];
      tick();
      exp = {e_held[i], e_press[i], e_rel[i], e_click[i],
             e_dbl[i], e_long[i], e_rep[i]};
      check($sformatf("%s[%0d]", name, i), {25'd0, obs_word()}, {25'd0, exp});
    end
    $display("[TB] %s: %0d edges, %0d bad", name, n, fails - line_fails);
    rst = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b0;
    bus.btn_db = 1'b1;

    // Reset held with the button high: everything quiet, state IDLE.
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("rst_out[%0d]", i), {25'd0, obs_word()}, 32'd0);
      check($sformatf("rst_state[%0d]", i), {29'd0, dut.state_reg}, {29'd0, IDLE});
    end
    rst = 1'b1;
    tick();
    check("rst_release_press", {25'd0, obs_word()}, {25'd0, 7'b1100000});
    $display("[TB] reset: press after release checked");

    //            name         n   btn        rst_low  held       press      release    click      dbl   long    rep
    do_reset();
    run_vec("single_click", 12, 32'h0000000E, 32'h0, 32'h0000000E, 32'h2, 32'h10, 32'h100, 32'h0, 32'h0, 32'h0);
    do_reset();
    run_vec("double_click", 14, 32'h00000066, 32'h0, 32'h00000066, 32'h22, 32'h88, 32'h0, 32'h20, 32'h0, 32'h0);
    do_reset();
    run_vec("gap_edge_dbl", 14, 32'h00000186, 32'h0, 32'h00000186, 32'h82, 32'h208, 32'h0, 32'h80, 32'h0, 32'h0);
    do_reset();
    run_vec("gap_past_click", 16, 32'h00000306, 32'h0, 32'h00000306, 32'h102, 32'h408, 32'h4080, 32'h0, 32'h0, 32'h0);
    do_reset();
    run_vec("long_repeat", 22, 32'h0000FFFE, 32'h0, 32'h0000FFFE, 32'h2, 32'h10000, 32'h0, 32'h0, 32'h100, 32'h4800);
    do_reset();
    run_vec("release_at_long", 16, 32'h000000FE, 32'h0, 32'h000000FE, 32'h2, 32'h100, 32'h1000, 32'h0, 32'h0, 32'h0);
    do_reset();
    run_vec("reset_mid_hold", 17, 32'h0001FFFE, 32'h40, 32'h0001FFBE, 32'h82, 32'h0, 32'h0, 32'h0, 32'h4000, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
